// File: rtl/scene_sequencer_if.sv
// Host scene-request handshake.
//   req_valid / req_scene : driven by the host, held until accepted.
//   req_ready             : driven by the sequencer. A request is accepted in
//                           any cycle where req_valid & req_ready are both high.
//                           req_ready never depends on frame_tick or pause, and
//                           is low outside HOLD.
interface scene_sequencer_if;
  logic       req_valid;
  logic [1:0] req_scene;
  logic       req_ready;

  modport master (output req_valid, output req_scene, input req_ready);
  modport slave  (input req_valid, input req_scene, output req_ready);
endinterface

// File: rtl/scene_sequencer.sv
// Frame-rate scene controller: picks the committed scene, runs wipe
// transitions triggered by the song position or by host requests, and keeps
// frame counters. All progress happens on advance events (frame_tick & !pause).
module scene_sequencer #(
  parameter int unsigned WIPE_STEP     = 2,
  parameter int unsigned WIPE_MAX      = 64,
  parameter int unsigned SETTLE_FRAMES = 32,
  parameter logic [1:0]  INITIAL_SCENE = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        pause,
  input  logic [10:0] song_position,
  scene_sequencer_if.slave req,
  output logic [1:0]  scene_cur,
  output logic [1:0]  scene_next,
  output logic [6:0]  wipe_pos,
  output logic        transitioning,
  output logic [12:0] frame_count,
  output logic [9:0]  scene_frames,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_WIPE   = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  localparam logic [7:0] STEP8       = 8'(WIPE_STEP);
  localparam logic [7:0] MAX8        = 8'(WIPE_MAX);
  localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_FRAMES - 1);

  state_t     state;
  logic       manual;
  logic [1:0] last_target;
  logic       primed;       // last_target holds a real sample

  logic       advance;
  logic [1:0] song_target;
  logic [1:0] last_eff;
  logic       song_changed;
  logic       manual_after;
  logic [7:0] wipe_sum;
  logic [7:0] wipe_clamped;
  logic       wipe_done;
  logic       unused_song_low;

  assign advance         = frame_tick & ~pause;
  assign song_target     = song_position[10:9];
  assign unused_song_low = ^song_position[8:0];

  // Request acceptance is purely combinational so the host sees it the same cycle.
  assign req.req_ready = req.req_valid & (state == S_HOLD);

  assign transitioning = (state == S_WIPE);
  assign dbg_state     = state;

  // Song-change detection and saturating wipe step (8-bit sum before clamp).
  always_comb begin
    last_eff     = primed ? last_target : song_target;
    song_changed = 1'b0;
    manual_after = manual;
    wipe_sum     = 8'd0;
    wipe_clamped = 8'd0;
    wipe_done    = 1'b0;
    song_changed = (song_target != last_eff);
    manual_after = manual & ~song_changed;
    wipe_sum     = {1'b0, wipe_pos} + STEP8;
    wipe_clamped = (wipe_sum >= MAX8) ? MAX8 : wipe_sum;
    wipe_done    = (wipe_clamped == MAX8);
  end

  // Scene FSM plus frame counters; a reset mid-wipe drops the wipe uncommitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_HOLD;
      scene_cur    <= INITIAL_SCENE;
      scene_next   <= INITIAL_SCENE;
      wipe_pos     <= 7'd0;
      frame_count  <= 13'd0;
      scene_frames <= 10'd0;
      manual       <= 1'b0;
      last_target  <= 2'd0;
      primed       <= 1'b0;
    end else begin
      // The first clock after reset captures the song target as the baseline.
      if (!primed) begin
        primed      <= 1'b1;
        last_target <= song_target;
      end

      if (advance) begin
        frame_count <= frame_count + 13'd1;
        if (scene_frames != 10'h3FF) begin
          scene_frames <= scene_frames + 10'd1;
        end
      end

      case (state)
        S_HOLD: begin
          if (req.req_ready) begin
            // A host request outranks the song check in the same cycle.
            manual <= 1'b1;
            if (req.req_scene != scene_cur) begin
              scene_next <= req.req_scene;
              wipe_pos   <= 7'd0;
              state      <= S_WIPE;
            end
          end else if (advance) begin
            if (song_changed) begin
              last_target <= song_target;
              manual      <= 1'b0;
            end
            if (!manual_after && (song_target != scene_cur)) begin
              scene_next <= song_target;
              wipe_pos   <= 7'd0;
              state      <= S_WIPE;
            end
          end
        end

        S_WIPE: begin
          if (advance) begin
            if (wipe_done) begin
              scene_cur    <= scene_next;
              scene_frames <= 10'd0;
              wipe_pos     <= 7'd0;
              state        <= S_SETTLE;
            end else begin
              wipe_pos <= wipe_clamped[6:0];
            end
          end
        end

        S_SETTLE: begin
          if (advance && (scene_frames == SETTLE_LAST)) begin
            state <= S_HOLD;
          end
        end

        default: state <= S_HOLD;
      endcase
    end
  end

endmodule
